wash_phase_responder: RTL and testbench
=======================================

Name: wash_phase_responder

Overview:
- Plant-side responder to the washing-machine mode controller.
- Consumes the controller's 3-bit mode (0 Standby, 1 Fill, 2 Rinse, 3 Wash, 4 Spin) and drives the actuators: water valve, drain pump, motor speed and door lock.
- Times each phase and returns a one-cycle phase_done pulse so the controller can advance.
- Polices the mode sequence and flags illegal transitions with a sticky error.

Parameters:
- FILL_MAX, 8: Fill timeout in cycles if water_full never rises.
- WASH_CYC, 12: cycles in Wash before done.
- RINSE_CYC, 10: cycles in Rinse before done.
- SPIN_CYC, 6: cycles at full speed (3) in Spin before done.
- RAMP_CYC, 2: cycles per motor speed step, up or down.
- TW, 8: phase timer width.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- mode  in  3  phase request from controller.
- water_full  in  1  level sensor, synchronous.
- door_closed  in  1  door switch, 1 = closed.
- valve_on  out  1  inlet valve.
- drain_on  out  1  drain pump.
- motor_spd  out  2  0 off, 1 agitate, 2 medium, 3 spin.
- door_lock  out  1  door latch.
- phase_done  out  1  one-cycle completion pulse.
- seq_err  out  1  sticky illegal-sequence flag.

Behaviour:
- One clock (clk); reset is asynchronous, active-low (rst_n).
- Reset:
  - All outputs 0; mode_q = 0 (Standby); timer = 0; ramp counter = 0; done_seen = 0.
  - Reset mid-phase drops every actuator immediately, with no ramp-down.
- mode is registered into mode_q each cycle. All outputs are registered, so actuators respond 1 cycle after mode changes.
- Legal changes: 0→1, 1→3, 3→2, 2→4, 4→0, and any→0 (abort). Holding the same value is always legal.
- Illegal change, or any mode value of 5–7:
  - seq_err is set and stays set until reset.
  - Block enters SAFE: valve_on = 0, drain_on = 1, motor ramps down to 0, no phase_done.
  - SAFE is left only by a return to mode 0.
- On any mode_q change: timer cleared, done_seen cleared, ramp counter cleared.
- Timer: increments once per cycle while the phase is active and not paused; saturates at 2^TW−1.
- Per-phase behaviour:
  - Standby: valve_on = 0, drain_on = 0. motor steps down 1 per RAMP_CYC to 0. door_lock = 1 while motor_spd ≠ 0, else 0. No done.
  - Fill: valve_on = 1 until done, then 0. motor_spd = 0. Done on the first cycle water_full is sampled 1, or when timer reaches FILL_MAX (timeout), whichever comes first.
  - Wash: motor_spd = 1; done when timer reaches WASH_CYC.
  - Rinse: drain_on = 1, motor_spd = 1; done when timer reaches RINSE_CYC.
  - Spin: drain_on = 1. motor ramps 1→2→3, one step per RAMP_CYC. Timer counts only while motor_spd = 3; done when it reaches SPIN_CYC.
- door_lock = 1 in every non-Standby phase and whenever motor_spd ≠ 0.
- phase_done:
  - Pulses exactly 1 cycle per phase entry. done_seen blocks repeats.
  - Actuators other than the Fill valve keep their phase values after done until mode changes.
- Pause: door_closed = 0 in a non-Standby phase.
  - valve_on = 0; motor ramps toward 0; timer frozen.
  - Resuming on door_closed = 1 restarts any ramp from the current speed.
  - Pending done is deferred while paused.
- Simultaneous events:
  - mode change in the same cycle as a done condition: the change wins, no pulse.
  - water_full and FILL_MAX in the same cycle: a single pulse.

Decomposition:
- Shared package holds:
  - mode codes MODE_STANDBY = 0, MODE_FILL = 1, MODE_RINSE = 2, MODE_WASH = 3, MODE_SPIN = 4;
  - motor speed codes;
  - legal-transition function, shared with the controller.
- One sub-module: wash_motor_ramp. Input: target speed; output: current speed; behaviour: step 1 every RAMP_CYC, with a busy flag.

Test Plan:
- Normal cycle: mode 0→1, water_full high 5 cycles after entry → valve_on 1 for 5 cycles, phase_done pulse once. Then 1→3 → done after 12 cycles. 3→2 → done after 10 cycles, drain_on = 1. 2→4 → motor 1,2,3 in 2-cycle steps, done 6 cycles after reaching 3. 4→0 → motor 3→2→1→0 over 6 cycles, door_lock falls with motor 0.
- Fill timeout: water_full held 0 in Fill → phase_done exactly at FILL_MAX = 8; valve_on 0 afterwards; no second pulse over 20 more cycles.
- Door open mid-Wash at timer = 5 for 4 cycles → motor 0 during pause, timer frozen; done 7 cycles after door closes.
- Illegal 0→4 → seq_err = 1, drain_on = 1, motor 0, no done. Then mode 0 then 1 → normal Fill, seq_err still 1. Reset → seq_err 0.
- Async reset asserted mid-Spin at motor_spd = 3 → all outputs 0 without waiting for a clock edge.
- mode changes 3→2 on the cycle the Wash timer would reach 12 → no Wash pulse; Rinse timer starts from 0.

Source files
------------

// File: rtl/wash_phase_responder_pkg.sv
// Shared definitions for the washing-machine mode controller and its plant-side responder.
// Mode/speed codes and the legal mode-transition rule live here so both ends agree.
package wash_phase_responder_pkg;

  typedef enum logic [2:0] {
    MODE_STANDBY = 3'd0,
    MODE_FILL    = 3'd1,
    MODE_RINSE   = 3'd2,
    MODE_WASH    = 3'd3,
    MODE_SPIN    = 3'd4
  } mode_e;

  typedef enum logic [1:0] {
    SPD_OFF     = 2'd0,
    SPD_AGITATE = 2'd1,
    SPD_MEDIUM  = 2'd2,
    SPD_SPIN    = 2'd3
  } motor_spd_e;

  localparam logic [2:0] MODE_LAST = 3'd4;

  // Holding a mode or aborting to Standby is always allowed; otherwise only the wash cycle order.
  function automatic logic mode_legal(input logic [2:0] cur_mode, input logic [2:0] nxt_mode);
    logic ok;
    ok = 1'b0;
    if (nxt_mode <= MODE_LAST) begin
      if ((nxt_mode == cur_mode) || (nxt_mode == MODE_STANDBY)) begin
        ok = 1'b1;
      end else begin
        case (cur_mode)
          MODE_STANDBY: ok = (nxt_mode == MODE_FILL);
          MODE_FILL:    ok = (nxt_mode == MODE_WASH);
          MODE_WASH:    ok = (nxt_mode == MODE_RINSE);
          MODE_RINSE:   ok = (nxt_mode == MODE_SPIN);
          default:      ok = 1'b0;
        endcase
      end
    end
    return ok;
  endfunction

endpackage

// File: rtl/wash_motor_ramp.sv
// Motor speed slewer: moves the current speed one step toward the target every RAMP_CYC cycles.
// clr_i restarts the step interval from the present speed without changing it.
module wash_motor_ramp
  import wash_phase_responder_pkg::*;
#(
  parameter int RAMP_CYC = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clr_i,
  input  logic [1:0] target_i,
  output logic [1:0] spd_o,
  output logic [1:0] spd_next_o,
  output logic       busy_o
);

  localparam int CW = (RAMP_CYC > 1) ? $clog2(RAMP_CYC) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(RAMP_CYC - 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0]    spd_q, spd_d;

  always_comb begin
    cnt_d = cnt_q;
    spd_d = spd_q;
    if (clr_i || (spd_q == target_i)) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_LAST) begin
      cnt_d = '0;
      spd_d = (target_i > spd_q) ? spd_q + 2'd1 : spd_q - 2'd1;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
      spd_q <= SPD_OFF;
    end else begin
      cnt_q <= cnt_d;
      spd_q <= spd_d;
    end
  end

  assign spd_o      = spd_q;
  assign spd_next_o = spd_d;
  assign busy_o     = (spd_q != target_i);

endmodule

// File: rtl/wash_phase_responder.sv
// Plant-side responder: drives valve, drain, motor and door lock from the controller's mode,
// times each phase, pulses phase_done once per phase entry and latches illegal sequences.
module wash_phase_responder
  import wash_phase_responder_pkg::*;
#(
  parameter int FILL_MAX  = 8,
  parameter int WASH_CYC  = 12,
  parameter int RINSE_CYC = 10,
  parameter int SPIN_CYC  = 6,
  parameter int RAMP_CYC  = 2,
  parameter int TW        = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [2:0] mode,
  input  logic       water_full,
  input  logic       door_closed,
  output logic       valve_on,
  output logic       drain_on,
  output logic [1:0] motor_spd,
  output logic       door_lock,
  output logic       phase_done,
  output logic       seq_err
);

  logic [2:0]    mode_q;
  logic [TW-1:0] timer_q, timer_d, timer_inc;
  logic          done_seen_q, done_seen_d;
  logic          safe_q, safe_d;
  logic          seq_err_q, seq_err_d;
  logic          paused_q, paused_d;
  logic          valve_q, valve_d;
  logic          drain_q, drain_d;
  logic          lock_q, lock_d;
  logic          done_q, done_d;

  logic          changed, illegal, ramp_clr, ramp_busy, at_speed;
  logic          run, done_cond, valve_phase, drain_phase;
  logic [1:0]    spd_target, spd_cur, spd_next;

  // Everything is decided from the incoming mode so the actuators follow one cycle after a change.
  always_comb begin
    changed    = (mode != mode_q);
    illegal    = !mode_legal(mode_q, mode);
    seq_err_d  = seq_err_q | illegal;
    safe_d     = illegal | (safe_q & (mode != MODE_STANDBY));
    paused_d   = (mode != MODE_STANDBY) & !door_closed;
    ramp_clr   = changed | (paused_d != paused_q);
    spd_target = SPD_OFF;
    if (!safe_d && !paused_d) begin
      case (mode)
        MODE_WASH:  spd_target = SPD_AGITATE;
        MODE_RINSE: spd_target = SPD_AGITATE;
        MODE_SPIN:  spd_target = SPD_SPIN;
        default:    spd_target = SPD_OFF;
      endcase
    end
  end

  wash_motor_ramp #(
    .RAMP_CYC (RAMP_CYC)
  ) u_ramp (
    .clk        (clk),
    .rst_n      (rst_n),
    .clr_i      (ramp_clr),
    .target_i   (spd_target),
    .spd_o      (spd_cur),
    .spd_next_o (spd_next),
    .busy_o     (ramp_busy)
  );

  always_comb begin
    timer_inc   = (timer_q == {TW{1'b1}}) ? timer_q : timer_q + 1'b1;
    at_speed    = (spd_cur == SPD_SPIN) && !ramp_busy;
    run         = 1'b0;
    done_cond   = 1'b0;
    valve_phase = 1'b0;
    drain_phase = 1'b0;
    case (mode)
      MODE_FILL: begin
        run         = 1'b1;
        valve_phase = 1'b1;
        done_cond   = water_full || (timer_inc == TW'(FILL_MAX));
      end
      MODE_WASH: begin
        run       = 1'b1;
        done_cond = (timer_inc == TW'(WASH_CYC));
      end
      MODE_RINSE: begin
        run         = 1'b1;
        drain_phase = 1'b1;
        done_cond   = (timer_inc == TW'(RINSE_CYC));
      end
      MODE_SPIN: begin
        // Spin time only counts once the drum is actually at full speed.
        run         = at_speed;
        drain_phase = 1'b1;
        done_cond   = at_speed && (timer_inc == TW'(SPIN_CYC));
      end
      default: ;
    endcase

    if (changed) begin
      timer_d = '0;
    end else if (run && !paused_d && !safe_d) begin
      timer_d = timer_inc;
    end else begin
      timer_d = timer_q;
    end

    done_d      = done_cond && !changed && !safe_d && !paused_d && !done_seen_q;
    done_seen_d = !changed && (done_seen_q || done_d);
    valve_d     = valve_phase && !safe_d && !paused_d && !done_seen_d;
    drain_d     = drain_phase || safe_d;
  end

  assign lock_d = (mode != MODE_STANDBY) || (spd_next != SPD_OFF);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode_q      <= MODE_STANDBY;
      timer_q     <= '0;
      done_seen_q <= 1'b0;
      safe_q      <= 1'b0;
      seq_err_q   <= 1'b0;
      paused_q    <= 1'b0;
      valve_q     <= 1'b0;
      drain_q     <= 1'b0;
      lock_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      mode_q      <= mode;
      timer_q     <= timer_d;
      done_seen_q <= done_seen_d;
      safe_q      <= safe_d;
      seq_err_q   <= seq_err_d;
      paused_q    <= paused_d;
      valve_q     <= valve_d;
      drain_q     <= drain_d;
      lock_q      <= lock_d;
      done_q      <= done_d;
    end
  end

  assign valve_on   = valve_q;
  assign drain_on   = drain_q;
  assign motor_spd  = spd_cur;
  assign door_lock  = lock_q;
  assign phase_done = done_q;
  assign seq_err    = seq_err_q;

endmodule

// File: tb/tb_wash_phase_responder.sv
// Directed bench for wash_phase_responder: stimulus queues expected pulses and output snapshots
// by cycle number; an independent negedge monitor pops and compares them.
module tb_wash_phase_responder;

  logic       clk;
  logic       rst_n;
  logic [2:0] mode;
  logic       water_full;
  logic       door_closed;
  logic       valve_on;
  logic       drain_on;
  logic [1:0] motor_spd;
  logic       door_lock;
  logic       phase_done;
  logic       seq_err;

  wash_phase_responder dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .mode        (mode),
    .water_full  (water_full),
    .door_closed (door_closed),
    .valve_on    (valve_on),
    .drain_on    (drain_on),
    .motor_spd   (motor_spd),
    .door_lock   (door_lock),
    .phase_done  (phase_done),
    .seq_err     (seq_err)
  );

  typedef struct {
    int         cyc;
    logic       valve;
    logic       drain;
    logic [1:0] motor;
    logic       lock;
    logic       err;
  } snap_t;

  int    checks = 0;
  int    errors = 0;
  int    cyc    = 0;
  int    t0     = 0;
  int    pq[$];
  snap_t snap_q[$];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  function automatic void chk(input string name, input int act, input int expv);
    checks++;
    if (act != expv) begin
      errors++;
      $display("FAIL %s: got %0d want %0d (cycle %0d)", name, act, expv, cyc);
    end
  endfunction

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Called just after an edge: the new mode is sampled on the next edge, which is j = 0.
  task automatic set_mode(input logic [2:0] m);
    mode = m;
    t0   = cyc + 1;
  endtask

  task automatic exp_at(input int j, input logic v, input logic d, input logic [1:0] m,
                        input logic l, input logic e);
    snap_t s;
    s.cyc   = t0 + j;
    s.valve = v;
    s.drain = d;
    s.motor = m;
    s.lock  = l;
    s.err   = e;
    snap_q.push_back(s);
  endtask

  task automatic pulse_at(input int j);
    pq.push_back(t0 + j);
  endtask

  always @(negedge clk) begin
    while (pq.size() > 0 && pq[0] < cyc) begin
      chk("pulse_slot", cyc, pq[0]);
      void'(pq.pop_front());
    end
    if (pq.size() > 0 && pq[0] == cyc) begin
      chk("pulse", int'(phase_done), 1);
      void'(pq.pop_front());
    end else if (phase_done) begin
      chk("stray_pulse", int'(phase_done), 0);
    end
    while (snap_q.size() > 0 && snap_q[0].cyc <= cyc) begin
      if (snap_q[0].cyc < cyc) begin
        chk("snap_slot", cyc, snap_q[0].cyc);
      end else begin
        chk("valve", int'(valve_on),  int'(snap_q[0].valve));
        chk("drain", int'(drain_on),  int'(snap_q[0].drain));
        chk("motor", int'(motor_spd), int'(snap_q[0].motor));
        chk("lock",  int'(door_lock), int'(snap_q[0].lock));
        chk("err",   int'(seq_err),   int'(snap_q[0].err));
        $display("snapshot cycle %0d: valve=%0b drain=%0b motor=%0d lock=%0b err=%0b",
                 cyc, valve_on, drain_on, motor_spd, door_lock, seq_err);
      end
      void'(snap_q.pop_front());
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit (cycle %0d)", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n       = 1'b0;
    mode        = 3'd0;
    water_full  = 1'b0;
    door_closed = 1'b1;
    step(2);
    chk("rst_valve", int'(valve_on), 0);
    chk("rst_drain", int'(drain_on), 0);
    chk("rst_motor", int'(motor_spd), 0);
    chk("rst_lock",  int'(door_lock), 0);
    chk("rst_done",  int'(phase_done), 0);
    chk("rst_err",   int'(seq_err), 0);
    $display("reset state checked");
    rst_n = 1'b1;
    step(1);

    // Normal cycle: Fill ended by water_full on the 5th cycle after entry.
    set_mode(3'd1);
    exp_at(0, 1, 0, 2'd0, 1, 0);
    exp_at(4, 1, 0, 2'd0, 1, 0);
    exp_at(5, 0, 0, 2'd0, 1, 0);
    exp_at(7, 0, 0, 2'd0, 1, 0);
    pulse_at(5);
    step(5);
    water_full = 1'b1;
    step(3);
    $display("fill by level done");

    set_mode(3'd3);
    water_full = 1'b0;
    exp_at(0,  0, 0, 2'd0, 1, 0);
    exp_at(1,  0, 0, 2'd0, 1, 0);
    exp_at(2,  0, 0, 2'd1, 1, 0);
    exp_at(12, 0, 0, 2'd1, 1, 0);
    pulse_at(12);
    step(14);
    $display("wash done");

    set_mode(3'd2);
    exp_at(0,  0, 1, 2'd1, 1, 0);
    exp_at(10, 0, 1, 2'd1, 1, 0);
    pulse_at(10);
    step(12);
    $display("rinse done");

    set_mode(3'd4);
    exp_at(0,  0, 1, 2'd1, 1, 0);
    exp_at(1,  0, 1, 2'd1, 1, 0);
    exp_at(2,  0, 1, 2'd2, 1, 0);
    exp_at(3,  0, 1, 2'd2, 1, 0);
    exp_at(4,  0, 1, 2'd3, 1, 0);
    exp_at(10, 0, 1, 2'd3, 1, 0);
    pulse_at(10);
    step(12);
    $display("spin done");

    set_mode(3'd0);
    exp_at(0, 0, 0, 2'd3, 1, 0);
    exp_at(1, 0, 0, 2'd3, 1, 0);
    exp_at(2, 0, 0, 2'd2, 1, 0);
    exp_at(4, 0, 0, 2'd1, 1, 0);
    exp_at(5, 0, 0, 2'd1, 1, 0);
    exp_at(6, 0, 0, 2'd0, 0, 0);
    step(8);
    $display("ramp down to standby done");

    // Fill timeout with water_full held low; one pulse only over the following 20 cycles.
    set_mode(3'd1);
    exp_at(0,  1, 0, 2'd0, 1, 0);
    exp_at(7,  1, 0, 2'd0, 1, 0);
    exp_at(8,  0, 0, 2'd0, 1, 0);
    exp_at(28, 0, 0, 2'd0, 1, 0);
    pulse_at(8);
    step(30);
    set_mode(3'd0);
    exp_at(0, 0, 0, 2'd0, 0, 0);
    step(2);
    $display("fill timeout done");

    // Door opened during Wash at timer 5 for 4 cycles.
    set_mode(3'd1);
    water_full = 1'b1;
    exp_at(0, 1, 0, 2'd0, 1, 0);
    exp_at(1, 0, 0, 2'd0, 1, 0);
    pulse_at(1);
    step(3);
    set_mode(3'd3);
    water_full = 1'b0;
    exp_at(2,  0, 0, 2'd1, 1, 0);
    exp_at(7,  0, 0, 2'd1, 1, 0);
    exp_at(8,  0, 0, 2'd0, 1, 0);
    exp_at(11, 0, 0, 2'd0, 1, 0);
    exp_at(12, 0, 0, 2'd1, 1, 0);
    exp_at(16, 0, 0, 2'd1, 1, 0);
    pulse_at(16);
    step(6);
    door_closed = 1'b0;
    step(4);
    door_closed = 1'b1;
    step(8);
    set_mode(3'd0);
    exp_at(0, 0, 0, 2'd1, 1, 0);
    exp_at(2, 0, 0, 2'd0, 0, 0);
    step(3);
    $display("door pause done");

    // Mode change on the cycle Wash would complete: no Wash pulse, Rinse times from zero.
    set_mode(3'd1);
    water_full = 1'b1;
    pulse_at(1);
    step(3);
    set_mode(3'd3);
    water_full = 1'b0;
    step(12);
    set_mode(3'd2);
    exp_at(0,  0, 1, 2'd1, 1, 0);
    exp_at(10, 0, 1, 2'd1, 1, 0);
    pulse_at(10);
    step(12);
    set_mode(3'd0);
    exp_at(0, 0, 0, 2'd1, 1, 0);
    exp_at(2, 0, 0, 2'd0, 0, 0);
    step(3);
    $display("change-beats-done done");

    // Illegal 0->4, recovery via Standby, sticky error, then out-of-range mode.
    set_mode(3'd4);
    exp_at(0, 0, 1, 2'd0, 1, 1);
    exp_at(2, 0, 1, 2'd0, 1, 1);
    step(3);
    set_mode(3'd0);
    exp_at(0, 0, 0, 2'd0, 0, 1);
    step(2);
    set_mode(3'd1);
    exp_at(0, 1, 0, 2'd0, 1, 1);
    exp_at(2, 0, 0, 2'd0, 1, 1);
    pulse_at(2);
    step(2);
    water_full = 1'b1;
    step(3);
    set_mode(3'd0);
    water_full = 1'b0;
    step(2);
    set_mode(3'd5);
    exp_at(0, 0, 1, 2'd0, 1, 1);
    step(2);
    set_mode(3'd0);
    exp_at(0, 0, 0, 2'd0, 0, 1);
    step(2);
    rst_n = 1'b0;
    #2;
    chk("err_cleared", int'(seq_err), 0);
    chk("err_rst_drain", int'(drain_on), 0);
    step(1);
    rst_n = 1'b1;
    step(1);
    $display("illegal sequence done");

    // Asynchronous reset in the middle of Spin at full speed.
    set_mode(3'd1);
    water_full = 1'b1;
    pulse_at(1);
    step(3);
    set_mode(3'd3);
    water_full = 1'b0;
    step(2);
    set_mode(3'd2);
    step(3);
    set_mode(3'd4);
    exp_at(6, 0, 1, 2'd3, 1, 0);
    step(8);
    #2;
    chk("pre_rst_motor", int'(motor_spd), 3);
    rst_n = 1'b0;
    #1;
    chk("arst_valve", int'(valve_on), 0);
    chk("arst_drain", int'(drain_on), 0);
    chk("arst_motor", int'(motor_spd), 0);
    chk("arst_lock",  int'(door_lock), 0);
    chk("arst_done",  int'(phase_done), 0);
    chk("arst_err",   int'(seq_err), 0);
    $display("async reset mid-spin done");
    step(1);
    mode  = 3'd0;
    rst_n = 1'b1;
    step(3);

    chk("pulses_left", pq.size(), 0);
    chk("snaps_left", snap_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
